// File: rtl/div32_seq.sv
// Iterative signed non-restoring divider, one add/sub per cycle; DIV32_REMAINDER_EN adds data_remainder.
// Result pulse WIDTH+2 edges after start (1 edge on divide-by-zero); a new ctrl_div always restarts.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
`ifdef DIV32_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [2:0]       w_state_nx;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_sub;
  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_q_fix;

  assign w_b_zero = (r_b == '0);
  assign w_abs_a  = r_sa ? (~r_a + 1'b1) : r_a;
  assign w_abs_b  = r_sb ? (~r_b + 1'b1) : r_b;

  // After PREP r_b holds |B|; zero-extended so |MIN| stays positive in WIDTH+1 bits.
  assign w_b_ext  = {1'b0, r_b};
  assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_sub    = ~r_rem[WIDTH];
  assign w_addend = w_sub ? ~w_b_ext : w_b_ext;
  assign w_rem_nx = w_rem_sh + w_addend + {{WIDTH{1'b0}}, w_sub};
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_rem_nx[WIDTH]};
  assign w_q_fix  = (r_sa ^ r_sb) ? (~r_quo + 1'b1) : r_quo;

`ifdef DIV32_REMAINDER_EN
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH:0]   w_rem_corr;
  logic [WIDTH-1:0] w_rem_out;

  assign w_rem_corr = r_rem[WIDTH] ? (r_rem + w_b_ext) : r_rem;
  assign w_rem_out  = r_sa ? (~w_rem_corr[WIDTH-1:0] + 1'b1) : w_rem_corr[WIDTH-1:0];
  assign data_remainder = r_remainder;
`endif

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = S_IDLE;
      S_PREP:  w_state_nx = w_b_zero ? S_DONE : S_ITER;
      S_ITER:  w_state_nx = (r_cnt == CW'(WIDTH - 1)) ? S_FIX : S_ITER;
      S_FIX:   w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // A start in any state wins, including DONE whose pulse is already registered.
    if (ctrl_div) begin
      w_state_nx = S_PREP;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx == S_ITER) || (w_state_nx == S_FIX);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (ctrl_div) begin
      r_a  <= data_operandA;
      r_b  <= data_operandB;
      r_sa <= data_operandA[WIDTH-1];
      r_sb <= data_operandB[WIDTH-1];
    end else begin
      case (r_state)
        S_PREP: begin
          if (!w_b_zero) begin
            r_b   <= w_abs_b;
            r_quo <= w_abs_a;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_ITER: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
`ifdef DIV32_REMAINDER_EN
      r_remainder <= '0;
`endif
    end else begin
      r_rdy <= 1'b0;
      if (!ctrl_div && (r_state == S_PREP) && w_b_zero) begin
        r_result <= '0;
        r_exc    <= 1'b1;
        r_rdy    <= 1'b1;
`ifdef DIV32_REMAINDER_EN
        r_remainder <= r_a;
`endif
      end else if (!ctrl_div && (r_state == S_FIX)) begin
        r_result <= w_q_fix;
        r_exc    <= 1'b0;
        r_rdy    <= 1'b1;
`ifdef DIV32_REMAINDER_EN
        r_remainder <= w_rem_out;
`endif
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign data_busy      = r_busy;

endmodule
